xui_mem_responder: RTL and testbench
====================================

XUI_MEM_RESPONDER -- requirements
Module: xui_mem_responder

Interface
REQ-001 SHALL have parameter addr_width_p, default 28: byte address width of app_addr_i.
REQ-002 SHALL have parameter data_width_p, default 512: one UI beat, equal to one cache block; power of two, at least 64.
REQ-003 SHALL have parameter els_p, default 1024: backing array depth in blocks; power of two.
REQ-004 SHALL have parameter rd_latency_p, default 4: cycles from read accept to data valid; at least 2.
REQ-005 SHALL have ports clk_i input 1: sole clock. reset_n_i input 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports app_addr_i input addr_width_p: byte address. app_cmd_i input 3: 000 write, 001 read. app_en_i input 1: command valid. app_rdy_o output 1: command ready.
REQ-007 SHALL have ports app_wdf_wren_i input 1: write data valid. app_wdf_data_i input data_width_p: write data. app_wdf_mask_i input data_width_p/8: 1 means the byte is not written. app_wdf_end_i input 1: last beat. app_wdf_rdy_o output 1: write data ready.
REQ-008 SHALL have ports app_rd_data_valid_o output 1, app_rd_data_o output data_width_p, app_rd_data_end_o output 1: read return with no backpressure.
REQ-009 SHALL have port err_o output 1: sticky protocol error.

Function
REQ-010 SHALL accept a command on app_en_i & app_rdy_o and a write beat on app_wdf_wren_i & app_wdf_rdy_o; both may fire in the same cycle.
REQ-011 SHALL compute the block index as app_addr_i[off +: log2(els_p)], with off = log2(data_width_p/8); higher address bits are ignored, so addresses alias modulo els_p blocks.
REQ-012 SHALL buffer write beats in a 2-entry FIFO; app_wdf_rdy_o = FIFO not full.
REQ-013 SHALL commit an accepted write command in its accept cycle when the FIFO is non-empty or a beat is pushed that cycle (same-cycle bypass); the oldest beat is popped and written with its byte mask.
REQ-014 SHALL otherwise record the write in a pending-write register (state WAIT_DATA); app_rdy_o = 0 in WAIT_DATA; the first beat accepted commits it and returns the block to IDLE the next cycle.
REQ-015 SHALL give states IDLE and WAIT_DATA, and IDLE on reset.
REQ-016 SHALL drive app_rdy_o = (state==IDLE) & (outstanding reads < rd_latency_p).
REQ-017 SHALL read the array for an accepted read and present data on app_rd_data_o with app_rd_data_valid_o = app_rd_data_end_o = 1 for exactly one cycle, rd_latency_p cycles after the accept cycle.
REQ-018 SHALL return reads in acceptance order; back-to-back reads on consecutive cycles produce valid on consecutive cycles.
REQ-019 SHALL make a read accepted after a write commit return the written data, including a read one cycle after the commit.
REQ-020 SHALL drive app_rd_data_o to 0 when app_rd_data_valid_o = 0.
REQ-021 SHALL set err_o on any of these events; the offending command or beat is still consumed:
- accepted command with app_cmd_i not 000/001 (dropped, no response);
- accepted beat with app_wdf_end_i = 0.
REQ-022 SHALL NOT set err_o for a write beat accepted with no write command pending; the beat remains queued for the next write command.

Reset
REQ-023 SHALL take effect immediately on reset_n_i = 0:
- state IDLE; FIFO and read pipeline emptied;
- app_rdy_o = 0, app_wdf_rdy_o = 0, app_rd_data_valid_o = 0, app_rd_data_end_o = 0, err_o = 0;
- array contents not reset.
REQ-024 SHALL discard reads in flight when reset is asserted mid-operation; none are returned after release.
REQ-025 SHALL raise app_rdy_o and app_wdf_rdy_o in the first clock edge after reset_n_i deasserts.

Configuration
REQ-026 With XUI_MEM_RANDOM_STALL_EN defined, SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) every cycle and AND bit 0 into app_rdy_o and bit 1 into app_wdf_rdy_o.
REQ-027 Without XUI_MEM_RANDOM_STALL_EN, SHALL build no LFSR, and app_rdy_o/app_wdf_rdy_o are as in REQ-012/REQ-016.

Verification
REQ-028 Scenario: write cmd plus beat in the same cycle, addr 0x40, data 0xA5 repeated, mask 0; then read addr 0x40 -> valid exactly 4 cycles after read accept, data 0xA5 repeated, end=1.
REQ-029 Scenario: write cmd with no beat -> app_rdy_o=0 next cycle; beat 3 cycles later -> commit; app_rdy_o=1; readback matches.
REQ-030 Scenario: 6 back-to-back reads of addresses 0x0,0x40,...,0x140 -> app_rdy_o drops after 4 outstanding; returns in order, no gaps once streaming.
REQ-031 Scenario: mask 0xFFFF...FFFE over prior data 0x11 repeated, new data 0x22 repeated -> only byte 0 reads 0x22.
REQ-032 Scenario: app_cmd_i=3'b010 accepted -> err_o=1 next cycle and stays 1; no read response; reset_n_i pulse clears err_o.
REQ-033 Scenario: reset asserted with 3 reads in flight -> no app_rd_data_valid_o after release; outputs at reset values during reset.

Source files
------------

// File: rtl/xui_mem_responder_if.sv
// rtl/xui_mem_responder_if.sv - UI command, write-data and read-return bundle for xui_mem_responder
interface xui_mem_responder_if #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 512
);
    logic [addr_width_p-1:0]   app_addr_i;
    logic [2:0]                app_cmd_i;
    logic                      app_en_i;
    logic                      app_rdy_o;

    logic                      app_wdf_wren_i;
    logic [data_width_p-1:0]   app_wdf_data_i;
    logic [data_width_p/8-1:0] app_wdf_mask_i;
    logic                      app_wdf_end_i;
    logic                      app_wdf_rdy_o;

    logic                      app_rd_data_valid_o;
    logic [data_width_p-1:0]   app_rd_data_o;
    logic                      app_rd_data_end_o;

    // Requester side: drives commands and write beats, receives read returns
    modport master (
        output app_addr_i, app_cmd_i, app_en_i,
        output app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
        input  app_rdy_o, app_wdf_rdy_o,
        input  app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o
    );

    // Responder side
    modport slave (
        input  app_addr_i, app_cmd_i, app_en_i,
        input  app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
        output app_rdy_o, app_wdf_rdy_o,
        output app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o
    );
endinterface

// File: rtl/xui_mem_responder.sv
// rtl/xui_mem_responder.sv - UI memory responder: 2-deep write FIFO, fixed-latency reads; optional XUI_MEM_RANDOM_STALL_EN
module xui_mem_responder #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 512,
    parameter int els_p        = 1024,
    parameter int rd_latency_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    xui_mem_responder_if.slave app,
    output logic               err_o
);
    localparam int mask_width_lp  = data_width_p / 8;
    localparam int off_lp         = $clog2(mask_width_lp);
    localparam int idx_width_lp   = $clog2(els_p);
    localparam int outst_width_lp = $clog2(rd_latency_p + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT_DATA = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic                      rdy_en_q;
    logic [idx_width_lp-1:0]   idx, pend_idx_q, pend_idx_d, commit_idx;
    logic                      cmd_rdy, wdf_rdy, cmd_fire, wr_fire, rd_fire, bad_fire;
    logic                      push, commit, go_wait, use_fifo, pop, store;
    logic [data_width_p-1:0]   commit_data;
    logic [mask_width_lp-1:0]  commit_mask;
    logic [1:0]                fifo_cnt_q, fifo_cnt_d;
    logic                      wr_ptr_q, rd_ptr_q;
    logic [data_width_p-1:0]   fifo_data_q [2];
    logic [mask_width_lp-1:0]  fifo_mask_q [2];
    logic [data_width_p-1:0]   mem_q [els_p];
    logic [rd_latency_p-1:0]   rd_vld_q, rd_vld_d;
    logic [data_width_p-1:0]   rd_data_q [rd_latency_p];
    logic [outst_width_lp-1:0] outst_q, outst_d;
    logic                      err_q, err_d;
    logic                      rd_out_vld;
    logic                      stall_cmd_ok, stall_wdf_ok;
    logic                      unused_addr;

`ifdef XUI_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Free-running stall pattern generator, restarts from a fixed seed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) lfsr_q <= 16'hACE1;
        else            lfsr_q <= lfsr_d;
    end

    assign stall_cmd_ok = lfsr_q[0];
    assign stall_wdf_ok = lfsr_q[1];
`else
    assign stall_cmd_ok = 1'b1;
    assign stall_wdf_ok = 1'b1;
`endif

    // Block index; low byte-offset bits and high bits beyond the array alias away
    assign idx         = app.app_addr_i[off_lp +: idx_width_lp];
    assign unused_addr = ^app.app_addr_i;

    // Readies stay low until the first edge after reset release (rdy_en_q)
    assign cmd_rdy = rdy_en_q & (state_q == S_IDLE)
                   & (outst_q < outst_width_lp'(rd_latency_p)) & stall_cmd_ok;
    assign wdf_rdy = rdy_en_q & (fifo_cnt_q != 2'd2) & stall_wdf_ok;

    assign app.app_rdy_o     = cmd_rdy;
    assign app.app_wdf_rdy_o = wdf_rdy;

    assign cmd_fire = app.app_en_i & cmd_rdy;
    assign wr_fire  = cmd_fire & (app.app_cmd_i == 3'b000);
    assign rd_fire  = cmd_fire & (app.app_cmd_i == 3'b001);
    assign bad_fire = cmd_fire & (app.app_cmd_i[2:1] != 2'b00);
    assign push     = app.app_wdf_wren_i & wdf_rdy;
    assign use_fifo = (fifo_cnt_q != 2'd0);

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state: park in WAIT_DATA only when a write has no beat to pair with
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (wr_fire && !(use_fifo || push)) state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (push)                           state_d = S_IDLE;
            default:                                         state_d = S_IDLE;
        endcase
    end

    // FSM outputs: when to commit a write and which block it targets
    always_comb begin
        commit     = 1'b0;
        commit_idx = idx;
        go_wait    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_fire) begin
                    if (use_fifo || push) commit  = 1'b1;
                    else                  go_wait = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                commit_idx = pend_idx_q;
                commit     = push;
            end
            default: ;
        endcase
    end

    // Oldest beat wins; an empty FIFO lets the incoming beat bypass straight to the array
    assign commit_data = use_fifo ? fifo_data_q[rd_ptr_q] : app.app_wdf_data_i;
    assign commit_mask = use_fifo ? fifo_mask_q[rd_ptr_q] : app.app_wdf_mask_i;
    assign pop         = commit & use_fifo;
    assign store       = push & ~(commit & ~use_fifo);
    assign fifo_cnt_d  = fifo_cnt_q + {1'b0, store} - {1'b0, pop};
    assign pend_idx_d  = go_wait ? idx : pend_idx_q;

    assign rd_out_vld = rd_vld_q[rd_latency_p-1];
    assign rd_vld_d   = {rd_vld_q[rd_latency_p-2:0], rd_fire};
    assign err_d      = err_q | bad_fire | (push & ~app.app_wdf_end_i);

    // Reads in flight, counted from accept until the cycle their data is presented
    always_comb begin
        outst_d = outst_q;
        if (rd_fire && !rd_out_vld)      outst_d = outst_q + outst_width_lp'(1);
        else if (!rd_fire && rd_out_vld) outst_d = outst_q - outst_width_lp'(1);
    end

    // Control registers: FIFO bookkeeping, read pipeline valids, error flag, ready enable
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdy_en_q   <= 1'b0;
            pend_idx_q <= '0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rd_vld_q   <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rdy_en_q   <= 1'b1;
            pend_idx_q <= pend_idx_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (store) wr_ptr_q <= ~wr_ptr_q;
            if (pop)   rd_ptr_q <= ~rd_ptr_q;
            rd_vld_q   <= rd_vld_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
        end
    end

    // Write-beat FIFO storage; contents are meaningless while the count says empty
    always_ff @(posedge clk_i) begin
        if (store) begin
            fifo_data_q[wr_ptr_q] <= app.app_wdf_data_i;
            fifo_mask_q[wr_ptr_q] <= app.app_wdf_mask_i;
        end
    end

    // Backing array write with byte mask (mask bit set = keep old byte)
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (!commit_mask[b]) mem_q[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
            end
        end
    end

    // Read data snapshot at accept, then carried down the fixed-latency pipe
    always_ff @(posedge clk_i) begin
        if (rd_fire) rd_data_q[0] <= mem_q[idx];
        for (int i = 1; i < rd_latency_p; i++) rd_data_q[i] <= rd_data_q[i-1];
    end

    assign app.app_rd_data_valid_o = rd_out_vld;
    assign app.app_rd_data_end_o   = rd_out_vld;
    assign app.app_rd_data_o       = rd_out_vld ? rd_data_q[rd_latency_p-1] : '0;
    assign err_o                   = err_q;
endmodule

// File: tb/tb_xui_mem_responder.sv
// tb/tb_xui_mem_responder.sv - directed and randomized self-checking bench for xui_mem_responder
module tb_xui_mem_responder;
    localparam int AW = 28;
    localparam int DW = 512;
    localparam int MW = DW / 8;

    typedef struct { logic [DW-1:0] d; logic [MW-1:0] m; } beat_t;
    typedef struct { logic [DW-1:0] d; int c; } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err;

    xui_mem_responder_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

    xui_mem_responder #(.addr_width_p(AW), .data_width_p(DW), .els_p(1024), .rd_latency_p(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .app(bus), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, rd_cnt = 0, last_rd_cyc = 0;
    bit seen = 1'b0, err_exp = 1'b0, c_ok, b_ok;
    logic [DW-1:0] last_rd;
    logic [DW-1:0] mem_m [int];
    beat_t beat_q [$];
    int    pend_q [$];
    exp_t  exp_q  [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int blk(input logic [AW-1:0] a);
        return (int'(a) / 64) % 1024;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < MW; b++) r[b*8 +: 8] = m[b] ? old_v[b*8 +: 8] : new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_blk();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) seen <= 1'b0;
        else          seen <= 1'b1;
    end

    // Reference model and output checker, evaluated mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_app_rdy", bus.app_rdy_o, 0);
            chk("rst_wdf_rdy", bus.app_wdf_rdy_o, 0);
            chk("rst_rd_valid", bus.app_rd_data_valid_o, 0);
            chk("rst_err", err, 0);
            beat_q.delete(); pend_q.delete(); exp_q.delete();
            err_exp = 1'b0;
        end else begin
            chk("app_rdy", bus.app_rdy_o, seen && pend_q.size() == 0 && exp_q.size() < 4);
            chk("wdf_rdy", bus.app_wdf_rdy_o, seen && beat_q.size() < 2);
            chk("err", err, err_exp);
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                chk("rd_valid", bus.app_rd_data_valid_o, 1);
                chk("rd_end", bus.app_rd_data_end_o, 1);
                chk("rd_data", bus.app_rd_data_o, exp_q[0].d);
                last_rd = bus.app_rd_data_o;
                last_rd_cyc = cyc;
                rd_cnt++;
                void'(exp_q.pop_front());
            end else begin
                chk("rd_idle_valid", bus.app_rd_data_valid_o, 0);
                chk("rd_idle_data", bus.app_rd_data_o, 0);
            end
            if (bus.app_wdf_wren_i && bus.app_wdf_rdy_o) begin
                beat_q.push_back('{d: bus.app_wdf_data_i, m: bus.app_wdf_mask_i});
                if (!bus.app_wdf_end_i) err_exp = 1'b1;
            end
            if (bus.app_en_i && bus.app_rdy_o) begin
                if (bus.app_cmd_i == 3'b000)      pend_q.push_back(blk(bus.app_addr_i));
                else if (bus.app_cmd_i != 3'b001) err_exp = 1'b1;
            end
            while (pend_q.size() > 0 && beat_q.size() > 0) begin
                int p;
                beat_t bt;
                p = pend_q.pop_front();
                bt = beat_q.pop_front();
                mem_m[p] = merge(mem_m.exists(p) ? mem_m[p] : '0, bt.d, bt.m);
            end
            if (bus.app_en_i && bus.app_rdy_o && bus.app_cmd_i == 3'b001)
                exp_q.push_back('{d: mem_m[blk(bus.app_addr_i)], c: cyc + 4});
        end
    end

    task automatic step_hs();
        @(negedge clk);
        c_ok = bus.app_en_i & bus.app_rdy_o;
        b_ok = bus.app_wdf_wren_i & bus.app_wdf_rdy_o;
        if (c_ok) acc_cyc = cyc;
        @(posedge clk); #1;
        if (c_ok) bus.app_en_i = 1'b0;
        if (b_ok) bus.app_wdf_wren_i = 1'b0;
    endtask

    task automatic send(input bit c_v, input logic [2:0] cmd, input logic [AW-1:0] addr,
                        input bit b_v, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit e);
        bus.app_en_i = c_v; bus.app_cmd_i = cmd; bus.app_addr_i = addr;
        bus.app_wdf_wren_i = b_v; bus.app_wdf_data_i = d; bus.app_wdf_mask_i = m; bus.app_wdf_end_i = e;
        for (int k = 0; k < 100 && (bus.app_en_i || bus.app_wdf_wren_i); k++) step_hs();
        chk("handshake_timeout", {bus.app_en_i, bus.app_wdf_wren_i}, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stream_reads(input int n, output int accepted, output int drops);
        accepted = 0; drops = 0;
        bus.app_en_i = 1'b1; bus.app_cmd_i = 3'b001; bus.app_addr_i = '0;
        for (int k = 0; k < 60 && accepted < n; k++) begin
            @(negedge clk);
            c_ok = bus.app_rdy_o;
            if (!c_ok) drops++;
            @(posedge clk); #1;
            if (c_ok) begin
                accepted++;
                bus.app_addr_i = AW'(accepted * 64);
            end
            if (accepted == n) bus.app_en_i = 1'b0;
        end
        bus.app_en_i = 1'b0;
    endtask

    logic [DW-1:0] pre [6];
    int t0, rc0, acc, drops, wc, bc;
    logic [AW-1:0] ra;

    initial begin
        bus.app_en_i = 0; bus.app_cmd_i = 0; bus.app_addr_i = 0; bus.app_wdf_wren_i = 0;
        bus.app_wdf_data_i = 0; bus.app_wdf_mask_i = 0; bus.app_wdf_end_i = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_first_edge", bus.app_rdy_o, 0);
        @(posedge clk); #1;
        chk("rdy_after_first_edge", bus.app_rdy_o, 1);
        chk("wdf_rdy_after_first_edge", bus.app_wdf_rdy_o, 1);

        // same-cycle write command and beat, then read back
        send(1, 3'b000, 28'h40, 1, {64{8'hA5}}, '0, 1);
        send(1, 3'b001, 28'h40, 0, '0, '0, 1);
        t0 = acc_cyc;
        idle(6);
        chk("s28_data", last_rd, {64{8'hA5}});
        chk("s28_latency", last_rd_cyc - t0, 4);

        // write command first, beat arrives later
        send(1, 3'b000, 28'hC0, 0, '0, '0, 1);
        @(negedge clk);
        chk("s29_rdy_wait", bus.app_rdy_o, 0);
        idle(2);
        send(0, 3'b000, '0, 1, {64{8'h5A}}, '0, 1);
        chk("s29_rdy_back", bus.app_rdy_o, 1);
        send(1, 3'b001, 28'hC0, 0, '0, '0, 1);
        idle(6);
        chk("s29_data", last_rd, {64{8'h5A}});

        // back-to-back reads with outstanding limit
        for (int i = 0; i < 6; i++) begin
            pre[i] = rand_blk();
            send(1, 3'b000, AW'(i * 64), 1, pre[i], '0, 1);
        end
        rc0 = rd_cnt;
        stream_reads(6, acc, drops);
        chk("s30_accepted", acc, 6);
        chk("s30_rdy_drops", drops, 1);
        idle(8);
        chk("s30_returns", rd_cnt - rc0, 6);
        chk("s30_last_data", last_rd, pre[5]);

        // byte mask keeps all but byte 0
        send(1, 3'b000, 28'h80, 1, {64{8'h11}}, '0, 1);
        send(1, 3'b000, 28'h80, 1, {64{8'h22}}, {{63{1'b1}}, 1'b0}, 1);
        send(1, 3'b001, 28'h80, 0, '0, '0, 1);
        idle(6);
        chk("s31_masked", last_rd, {{63{8'h11}}, 8'h22});

        // illegal command: sticky error, no response, cleared by reset
        rc0 = rd_cnt;
        send(1, 3'b010, 28'h100, 0, '0, '0, 1);
        @(negedge clk);
        chk("s32_err_set", err, 1);
        idle(6);
        chk("s32_err_sticky", err, 1);
        chk("s32_no_response", rd_cnt - rc0, 0);
        reset_n = 1'b0;
        #1;
        chk("s32_err_cleared", err, 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(1, 3'b000, 28'h240, 1, rand_blk(), '0, 0);
        @(negedge clk);
        chk("beat_no_end_err", err, 1);
        idle(1);

        // reset with reads in flight
        stream_reads(3, acc, drops);
        chk("s33_accepted", acc, 3);
        reset_n = 1'b0;
        #1;
        chk("s33_rd_valid_rst", bus.app_rd_data_valid_o, 0);
        chk("s33_rd_end_rst", bus.app_rd_data_end_o, 0);
        chk("s33_rd_data_rst", bus.app_rd_data_o, 0);
        chk("s33_rdy_rst", bus.app_rdy_o, 0);
        chk("s33_err_rst", err, 0);
        idle(2);
        reset_n = 1'b1;
        rc0 = rd_cnt;
        idle(10);
        chk("s33_no_stale_return", rd_cnt - rc0, 0);

        // randomized traffic over aliased addresses of blocks 0..7
        for (int i = 0; i < 8; i++) send(1, 3'b000, AW'(i * 64), 1, rand_blk(), '0, 1);
        wc = 0; bc = 0;
        for (int k = 0; k < 300; k++) begin
            if (!bus.app_en_i && ($urandom % 3) == 0) begin
                int r;
                r = $urandom % 16;
                bus.app_cmd_i = (r == 0) ? 3'(2 + $urandom % 6) : ((r < 8) ? 3'b000 : 3'b001);
                ra = AW'((($urandom % 4096) << 16) | (($urandom % 8) << 6) | ($urandom % 64));
                bus.app_addr_i = ra;
                bus.app_en_i = 1'b1;
                if (bus.app_cmd_i == 3'b000) wc++;
            end
            if (!bus.app_wdf_wren_i && bc < wc + 2 && ($urandom % 2) == 1) begin
                bus.app_wdf_wren_i = 1'b1;
                bus.app_wdf_data_i = rand_blk();
                bus.app_wdf_mask_i = (($urandom % 4) == 0) ? {$urandom, $urandom} : '0;
                bus.app_wdf_end_i = 1'b1;
                bc++;
            end
            step_hs();
        end
        for (int k = 0; k < 100 && (bus.app_en_i || bus.app_wdf_wren_i); k++) step_hs();
        chk("rand_handshake_drain", {bus.app_en_i, bus.app_wdf_wren_i}, 0);
        while (bc < wc) begin send(0, 3'b000, '0, 1, rand_blk(), '0, 1); bc++; end
        while (wc < bc) begin send(1, 3'b000, AW'(($urandom % 8) * 64), 0, '0, '0, 1); wc++; end
        send(1, 3'b001, 28'h1C0, 0, '0, '0, 1);
        idle(10);
        chk("rand_reads_drained", exp_q.size(), 0);
        chk("rand_pending_drained", pend_q.size() + beat_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
